// File: rtl/disp7_pkg.sv
// Shared page encoding, segment constants and helpers for the 7-segment pager.
package disp7_pkg;

    typedef enum logic [1:0] {
        P_MAIN = 2'd0,
        P_SUB  = 2'd1,
        P_MEAS = 2'd2
    } page_t;

    // Segment patterns, bit0 = seg a ... bit6 = seg g
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;

    // Decimal digit to segment pattern; non-decimal codes show blank
    function automatic logic [6:0] hex2seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // 10^n, the first value that no longer fits in n decimal digits
    function automatic logic [31:0] pow10(input int unsigned n);
        logic [31:0] r;
        r = 32'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential double-dabble: MW shift cycles per conversion, START restarts.
module bin2bcd #(
    parameter int unsigned MW = 8,
    parameter int unsigned ND = 3
) (
    input  logic              CLK,
    input  logic              RSTX,
    input  logic              START,
    input  logic [MW-1:0]     BIN,
    output logic              BUSY,
    output logic              DONE,
    output logic [4*ND-1:0]   BCD
);

    localparam int unsigned CW = $clog2(MW + 1);

    logic [MW-1:0]   bin_q;
    logic [4*ND-1:0] bcd_q;
    logic [4*ND-1:0] adj_c;
    logic [CW-1:0]   cnt;

    // Add-3 correction on every BCD nibble that is 5 or more
    always_comb begin
        adj_c = '0;
        for (int i = 0; i < int'(ND); i++) begin
            adj_c[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                       : bcd_q[4*i +: 4];
        end
    end

    // Load on START, then shift one binary bit into the BCD field per cycle
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else if (START) begin
            bin_q <= BIN;
            bcd_q <= '0;
            cnt   <= CW'(MW);
            BUSY  <= 1'b1;
            DONE  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (BUSY) begin
                {bcd_q, bin_q} <= {adj_c[4*ND-2:0], bin_q, 1'b0};
                cnt            <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    BUSY <= 1'b0;
                    DONE <= 1'b1;
                end
            end
        end
    end

    assign BCD = bcd_q;

endmodule

// File: rtl/disp7_pager.sv
// Multiplexed 7-segment pager: MAIN mode, SUB mode, then measurement page.
// Optional build macro DISP7_PAGER_REFRESH_EN: keep re-requesting measurements
// every dwell period while the measurement page is shown.
module disp7_pager
    import disp7_pkg::*;
#(
    parameter int unsigned N_DIGIT = 4,
    parameter int unsigned MW      = 8,
    parameter int unsigned DWELL   = 10_000_000,
    parameter int unsigned SCAN    = 50
) (
    input  logic                   CLK,
    input  logic                   RSTX,
    input  logic [MW-1:0]          MAIN_MODE,
    input  logic [MW-1:0]          SUB_MODE,
    input  logic                   MEAS_EN,
    input  logic [7*N_DIGIT-1:0]   MEAS_SEG,
    input  logic                   MEAS_VALID,
    output logic                   MEAS_START,
    output logic [N_DIGIT-1:0]     DIGIT_SEL,
    output logic [7:0]             DIGIT
);

    localparam int unsigned ND = N_DIGIT - 1;
    localparam int unsigned BW = 4 * ND;
    localparam int unsigned DW = $clog2(DWELL + 1);
    localparam int unsigned SW = $clog2(SCAN + 1);
    localparam int unsigned IW = $clog2(N_DIGIT);
    localparam logic [31:0] OVF_LIM = pow10(ND);

    logic [MW-1:0] main_sh, sub_sh;
    logic          main_chg_c, sub_chg_c, chg_c;

    page_t         page, page_nxt;
    logic [DW-1:0] dwell, dwell_nxt;
    logic          meas_start_nxt;

    logic                 meas_ok;
    logic [7*N_DIGIT-1:0] meas_q;

    logic          conv_sub, main_rdy, sub_rdy;
    logic [BW-1:0] main_bcd, sub_bcd;
    logic          cv_start_c, cv_busy, cv_done, cv_accept_c;
    logic [MW-1:0] cv_bin_c;
    logic [BW-1:0] cv_bcd;

    logic [SW-1:0] scan_cnt;
    logic [IW-1:0] idx;
    logic [6:0]    seg_c;

    assign main_chg_c = (MAIN_MODE != main_sh);
    assign sub_chg_c  = (SUB_MODE != sub_sh);
    assign chg_c      = main_chg_c || sub_chg_c;

    // Mode shadows track the inputs every cycle for change detection
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            main_sh <= '1;
            sub_sh  <= '1;
        end else begin
            main_sh <= MAIN_MODE;
            sub_sh  <= SUB_MODE;
        end
    end

    // Page state register with dwell counter and measurement request
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            page       <= P_MAIN;
            dwell      <= DW'(DWELL - 1);
            MEAS_START <= 1'b0;
        end else begin
            page       <= page_nxt;
            dwell      <= dwell_nxt;
            MEAS_START <= meas_start_nxt;
        end
    end

    // Page next-state: a change event overrides any dwell expiry
    always_comb begin
        page_nxt       = page;
        dwell_nxt      = dwell;
        meas_start_nxt = 1'b0;
        if (chg_c) begin
            page_nxt       = (sub_chg_c && !main_chg_c) ? P_SUB : P_MAIN;
            dwell_nxt      = DW'(DWELL - 1);
            meas_start_nxt = sub_chg_c && !main_chg_c;
        end else begin
            case (page)
                P_MAIN: begin
                    if (dwell == '0) begin
                        page_nxt       = P_SUB;
                        dwell_nxt      = DW'(DWELL - 1);
                        meas_start_nxt = 1'b1;
                    end else begin
                        dwell_nxt = dwell - DW'(1);
                    end
                end
                P_SUB: begin
                    if (dwell == '0) begin
                        page_nxt  = P_MEAS;
                        dwell_nxt = DW'(DWELL - 1);
                    end else begin
                        dwell_nxt = dwell - DW'(1);
                    end
                end
                P_MEAS: begin
`ifdef DISP7_PAGER_REFRESH_EN
                    if (dwell == '0) begin
                        dwell_nxt      = DW'(DWELL - 1);
                        meas_start_nxt = 1'b1;
                    end else begin
                        dwell_nxt = dwell - DW'(1);
                    end
`endif
                end
                default: page_nxt = P_MAIN;
            endcase
        end
    end

    // Latch the formatter's final pattern; a change invalidates it
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            meas_ok <= 1'b0;
            meas_q  <= '0;
        end else if (chg_c) begin
            meas_ok <= 1'b0;
        end else if (MEAS_VALID) begin
            meas_ok <= 1'b1;
            meas_q  <= MEAS_SEG;
        end
    end

    // Convert MAIN first, then SUB; any change aborts and restarts with MAIN
    assign cv_accept_c = cv_done && !cv_busy && !chg_c;
    assign cv_start_c  = chg_c || (cv_accept_c && !conv_sub);
    assign cv_bin_c    = chg_c ? MAIN_MODE : SUB_MODE;

    bin2bcd #(
        .MW (MW),
        .ND (ND)
    ) u_bin2bcd (
        .CLK   (CLK),
        .RSTX  (RSTX),
        .START (cv_start_c),
        .BIN   (cv_bin_c),
        .BUSY  (cv_busy),
        .DONE  (cv_done),
        .BCD   (cv_bcd)
    );

    // Hold conversion results until the next change event
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            conv_sub <= 1'b0;
            main_rdy <= 1'b0;
            sub_rdy  <= 1'b0;
            main_bcd <= '0;
            sub_bcd  <= '0;
        end else if (chg_c) begin
            conv_sub <= 1'b0;
            main_rdy <= 1'b0;
            sub_rdy  <= 1'b0;
        end else if (cv_accept_c) begin
            if (!conv_sub) begin
                main_bcd <= cv_bcd;
                main_rdy <= 1'b1;
                conv_sub <= 1'b1;
            end else begin
                sub_bcd <= cv_bcd;
                sub_rdy <= 1'b1;
            end
        end
    end

    // Free-running scan: digit index steps every SCAN cycles
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SW'(SCAN - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IW'(N_DIGIT - 1)) ? '0 : idx + IW'(1);
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    // Segment pattern for the digit currently indexed on the current page
    always_comb begin
        logic          rdy;
        logic          ovf;
        logic [6:0]    letter;
        logic [BW-1:0] val;
        logic [3:0]    nib;
        logic [6:0]    mseg;

        seg_c  = SEG_BLANK;
        rdy    = (page == P_SUB) ? sub_rdy : main_rdy;
        ovf    = (page == P_SUB) ? (32'(sub_sh) >= OVF_LIM) : (32'(main_sh) >= OVF_LIM);
        letter = (page == P_SUB) ? SEG_B : SEG_A;
        val    = (page == P_SUB) ? sub_bcd : main_bcd;
        nib    = 4'd0;
        mseg   = SEG_BLANK;
        for (int i = 0; i < int'(ND); i++) begin
            if (idx == IW'(i)) nib = val[4*i +: 4];
        end
        for (int i = 0; i < int'(N_DIGIT); i++) begin
            if (idx == IW'(i)) mseg = meas_q[7*i +: 7];
        end

        case (page)
            P_MAIN, P_SUB: begin
                if (rdy) begin
                    if (idx == IW'(N_DIGIT - 1)) seg_c = letter;
                    else if (ovf)                seg_c = SEG_DASH;
                    else                         seg_c = hex2seg(nib);
                end
            end
            P_MEAS:  seg_c = (MEAS_EN && meas_ok) ? mseg : SEG_DASH;
            default: seg_c = SEG_BLANK;
        endcase
    end

    // Select and segments registered together so digits never ghost
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            DIGIT_SEL <= N_DIGIT'(1);
            DIGIT     <= 8'd0;
        end else begin
            DIGIT_SEL <= N_DIGIT'(1) << idx;
            DIGIT     <= {1'b0, seg_c};
        end
    end

endmodule

// File: tb/tb_disp7_pager.sv
// Bench for disp7_pager: a 4-digit and a 3-digit instance share stimulus;
// an edge-indexed reference model queues expected outputs, a monitor checks.
module tb_disp7_pager;

    localparam int MW    = 8;
    localparam int DWELL = 20;
    localparam int SCAN  = 4;
`ifdef DISP7_PAGER_REFRESH_EN
    localparam bit REFRESH = 1'b1;
`else
    localparam bit REFRESH = 1'b0;
`endif

    localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic        CLK = 1'b0;
    logic        RSTX;
    logic [7:0]  main_mode, sub_mode;
    logic        meas_en, meas_valid;
    logic [27:0] meas_seg;
    logic        st0, st1;
    logic [3:0]  sel0;
    logic [2:0]  sel1;
    logic [7:0]  dig0, dig1;

    always #5 CLK = ~CLK;

    disp7_pager #(.N_DIGIT(4), .MW(MW), .DWELL(DWELL), .SCAN(SCAN)) u_dut4 (
        .CLK(CLK), .RSTX(RSTX), .MAIN_MODE(main_mode), .SUB_MODE(sub_mode),
        .MEAS_EN(meas_en), .MEAS_SEG(meas_seg), .MEAS_VALID(meas_valid),
        .MEAS_START(st0), .DIGIT_SEL(sel0), .DIGIT(dig0));

    disp7_pager #(.N_DIGIT(3), .MW(MW), .DWELL(DWELL), .SCAN(SCAN)) u_dut3 (
        .CLK(CLK), .RSTX(RSTX), .MAIN_MODE(main_mode), .SUB_MODE(sub_mode),
        .MEAS_EN(meas_en), .MEAS_SEG(meas_seg[20:0]), .MEAS_VALID(meas_valid),
        .MEAS_START(st1), .DIGIT_SEL(sel1), .DIGIT(dig1));

    typedef struct packed {
        logic [7:0] sel0, dig0, sel1, dig1;
        logic       st;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state; m_k is the index of the next clock edge since reset release
    int          m_k, m_entry, m_chg_k, m_page, m_main, m_sub;
    bit          m_any, m_ok;
    logic [7:0]  m_msh, m_ssh;
    logic [27:0] m_pat;

    function automatic int p10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    task automatic model_reset();
        m_k = 0; m_entry = -1; m_chg_k = 0; m_page = 0; m_main = 0; m_sub = 0;
        m_any = 0; m_ok = 0; m_msh = 8'hFF; m_ssh = 8'hFF; m_pat = '0;
    endtask

    // Expected segments for digit idx of an n-digit display, from pre-edge model state
    function automatic logic [6:0] exp_seg(input int n, input int idx, input logic en);
        int v;
        bit rdy;
        if (m_page == 2) return (en && m_ok) ? m_pat[7*idx +: 7] : 7'h40;
        // MAIN result usable MW+2 edges after the change, SUB a further MW+1 later
        rdy = m_any && ((m_page == 0) ? (m_k >= m_chg_k + MW + 2) : (m_k >= m_chg_k + 2*MW + 3));
        if (!rdy) return 7'h00;
        if (idx == n - 1) return (m_page == 0) ? 7'h77 : 7'h7C;
        v = (m_page == 0) ? m_main : m_sub;
        if (v >= p10(n - 1)) return 7'h40;
        return SEG_TAB[(v / p10(idx)) % 10];
    endfunction

    // Model: predict outputs after this edge, then apply the edge's events
    always @(posedge CLK) begin
        if (RSTX) begin
            exp_t e;
            bit   mc, sc, st;
            int   i4, i3;
            i4 = (m_k / SCAN) % 4;
            i3 = (m_k / SCAN) % 3;
            e.sel0 = 8'(1 << i4);
            e.sel1 = 8'(1 << i3);
            e.dig0 = {1'b0, exp_seg(4, i4, meas_en)};
            e.dig1 = {1'b0, exp_seg(3, i3, meas_en)};
            mc = (main_mode != m_msh);
            sc = (sub_mode != m_ssh);
            m_msh = main_mode;
            m_ssh = sub_mode;
            st = 1'b0;
            if (mc || sc) begin
                m_page = (sc && !mc) ? 1 : 0;
                m_entry = m_k; m_chg_k = m_k; m_any = 1;
                m_main = int'(main_mode); m_sub = int'(sub_mode);
                m_ok = 0;
                st = (m_page == 1);
            end else begin
                if (meas_valid) begin m_ok = 1; m_pat = meas_seg; end
                if (m_page < 2 && (m_k - m_entry) == DWELL) begin
                    m_page = m_page + 1;
                    m_entry = m_k;
                    st = (m_page == 1);
                end else if (REFRESH && m_page == 2 && m_k > m_entry && ((m_k - m_entry) % DWELL) == 0) begin
                    st = 1'b1;
                end
            end
            e.st = st;
            q.push_back(e);
            m_k = m_k + 1;
        end
    end

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30)
                $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    // Monitor: compare every registered output update against the queued prediction
    always @(negedge CLK) begin
        if (RSTX && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("sel4", {4'd0, sel0}, e.sel0);
            check("dig4", dig0, e.dig0);
            check("start4", {7'd0, st0}, {7'd0, e.st});
            check("sel3", {5'd0, sel1}, e.sel1);
            check("dig3", dig1, e.dig1);
            check("start3", {7'd0, st1}, {7'd0, e.st});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_valid(input logic [27:0] pat);
        meas_seg = pat; meas_valid = 1'b1;
        cyc(1);
        meas_valid = 1'b0;
    endtask

    task automatic reset_checks();
        check("rst_sel4", {4'd0, sel0}, 8'h01);
        check("rst_dig4", dig0, 8'h00);
        check("rst_start4", {7'd0, st0}, 8'h00);
        check("rst_sel3", {5'd0, sel1}, 8'h01);
        check("rst_dig3", dig1, 8'h00);
        check("rst_start3", {7'd0, st1}, 8'h00);
    endtask

    initial begin
        bit ok;
        RSTX = 1'b0; main_mode = 8'd123; sub_mode = 8'd7;
        meas_en = 1'b0; meas_valid = 1'b0; meas_seg = '0;
        model_reset();
        cyc(3);
        #1 reset_checks();
        #1 RSTX = 1'b1;

        // MAIN page, SUB page with start pulse, then a measurement arrives
        cyc(26);
        meas_en = 1'b1;
        pulse_valid(28'hFFFFFFF);
        cyc(30);
        meas_en = 1'b0; cyc(12);
        meas_en = 1'b1; cyc(12);

        // SUB-only change from the measurement page
        sub_mode = 8'd42;
        cyc(50);
        pulse_valid(28'($urandom));
        cyc(10);

        // MAIN change landing exactly on a MAIN dwell expiry
        main_mode = 8'd200;
        cyc(1);
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            if (m_page == 0 && (m_k - m_entry) == DWELL) begin ok = 1; break; end
            cyc(1);
        end
        check("expiry_sync", {7'd0, ok}, 8'h01);
        main_mode = 8'd77;
        cyc(40);

        // Measurement valid coinciding with a change must be ignored
        main_mode = 8'd5;
        meas_seg = 28'($urandom); meas_valid = 1'b1;
        cyc(1);
        meas_valid = 1'b0;
        cyc(60);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(39, 0) == 0) main_mode = 8'($urandom);
            if ($urandom_range(39, 0) == 0) sub_mode = 8'($urandom_range(120, 0));
            if ($urandom_range(29, 0) == 0) meas_en = ~meas_en;
            if ($urandom_range(9, 0) == 0) begin
                meas_seg = 28'($urandom); meas_valid = 1'b1;
            end else begin
                meas_valid = 1'b0;
            end
            cyc(1);
        end
        meas_valid = 1'b0;

        // Reset in the middle of a conversion
        main_mode = 8'd99;
        cyc(3);
        #2 RSTX = 1'b0;
        #1 reset_checks();
        q.delete();
        model_reset();
        cyc(2);
        #2 RSTX = 1'b1;
        cyc(80);

        cyc(2);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
